if2_stage: RTL
==============

Name: if2_stage

Overview:
- Second instruction-fetch stage. Sits between the PC/fetch-request stage (IF1) and decode (ID).
- Registers the fetch PC issued by IF1 one cycle earlier and pairs it with the instruction returned by the synchronous inst SRAM (1-cycle read latency).
- Holds the instruction in a local buffer across stalls, kills wrong-path fetches on branch redirect, and drives the IF2→ID bus.

Parameters:
- NOP_INST, 32'h0000_0013, instruction emitted when the output is invalid (addi x0,x0,0).
- RESET_PC, 32'h0000_0000, reset value of the registered PC.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- stall  in  `StallBus  pipeline stall vector; bit1 = IF2 hold, bit2 = ID hold.
- if12if2_bus  in  `IF12IF2_WD (32)  fetch PC from IF1.
- if1_valid  in  1  IF1 issued a real fetch this cycle (same signal as IF1's inst_sram_en).
- br_bus  in  33  {br_e, br_addr} redirect from EX; only br_e is used.
- inst_sram_rdata  in  32  SRAM read data for the request issued in the previous cycle.
- if22id_bus  out  `IF22ID_WD (66)  {valid, excp_misalign, pc[31:0], inst[31:0]}.

Behaviour:
- Registers: v_r (valid), pc_r, buf_v, buf_inst.
- Reset (rst_n=0 at posedge):
  - v_r=0, pc_r=RESET_PC, buf_v=0, buf_inst=NOP_INST.
  - if22id_bus = {0,0,RESET_PC,NOP_INST}.
- Register update priority per posedge: reset > flush (br_e) > hold (stall[1]) > advance.
- Flush (br_e=1): v_r<=0, buf_v<=0, pc_r<=pc_in. The flush applies even if stall[1]=1.
- Advance (!stall[1], !br_e): v_r<=if1_valid, pc_r<=pc_in, buf_v<=0.
- Hold (stall[1]=1):
  - If stall[2]=0, ID advances while IF2 holds, so IF2 inserts a bubble: v_r<=0, buf_v<=0.
  - If stall[2]=1, v_r and pc_r hold.
  - If additionally v_r=1 and buf_v=0: buf_inst<=inst_sram_rdata, buf_v<=1. This captures the data before the SRAM output changes.
- Instruction select (comb): inst_sel = buf_v ? buf_inst : inst_sram_rdata.
- Output (comb):
  - valid_o = v_r & ~br_e. Same-cycle kill, so a wrong-path instruction never enters ID.
  - excp_misalign = valid_o & (pc_r[1:0]!=0).
  - inst_o = valid_o ? inst_sel : NOP_INST.
  - pc_o = pc_r.
- Latency: PC presented on inst_sram_addr in cycle t appears on if22id_bus in cycle t+1 (zero added latency beyond the SRAM).
- A buffered instruction survives any number of consecutive stall cycles. It is released in the first non-stalled cycle, then buf_v clears.
- if1_valid=0 (IF1 suppressed its fetch on redirect) always yields v_r=0 on the next cycle regardless of rdata.
- Reset asserted mid-stall with buf_v=1: buffer is dropped, output invalid on the next cycle.

Decomposition:
- Shared define.vh:
  - add `IF22ID_WD (66) and a NOP_INST constant.
  - document the stall bit assignments (0=IF1, 1=IF2, 2=ID).
- Optional sub-module if2_inst_buf: the 1-entry hold buffer (buf_v/buf_inst, capture/release/flush). Useful because ID and MEM load-data paths will reuse it.
- The remaining logic stays flat.

Test Plan:
- Straight-line run:
  - Stimulus: no stalls; IF1 pcs 0x80000000, 0x80000004, 0x80000008; rdata 0x00100093, 0x00200113, 0x00300193 each one cycle later.
  - Response: bus shows {1,0,pc,inst} pairs each one cycle after issue.
- Stall with buffering:
  - Stimulus: v_r=1, pc 0x80000004, rdata 0x00200113; stall=3'b111 for 3 cycles while rdata changes to 0xDEADBEEF.
  - Response: output holds {1,0,0x80000004,0x00200113} throughout and after release.
- Branch flush:
  - Stimulus: br_e=1 for one cycle while v_r=1.
  - Response: valid_o=0 and inst=0x00000013 that cycle; next cycle valid=0, because IF1 drove if1_valid=0.
- Bubble insertion:
  - Stimulus: stall=3'b011 (IF2 held, ID free) for 1 cycle.
  - Response: next cycle valid=0, buf_v=0.
- Reset mid-stall:
  - Stimulus: buf_v=1, assert rst_n=0 one cycle.
  - Response: output {0,0,RESET_PC,0x00000013}; no stale instruction appears after reset release.
- Misaligned fetch:
  - Stimulus: pc_in 0x80000002 with if1_valid=1.
  - Response: excp_misalign=1, valid=1.

Source files
------------

// File: rtl/if2_stage_pkg.sv
// Shared IF2 definitions: bus widths, stall-vector bit positions, default
// constants and the IF2->ID / redirect bus payload layouts.
// Stall vector bits: 0 = IF1 hold, 1 = IF2 hold, 2 = ID hold (upper bits
// belong to later stages).
package if2_stage_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INST_W      = 32;
    localparam int unsigned STALL_W     = 6;
    localparam int unsigned IF12IF2_WD  = 32;
    localparam int unsigned IF22ID_WD   = 66;
    localparam int unsigned BR_BUS_WD   = 33;

    localparam int unsigned STALL_IF1   = 0;
    localparam int unsigned STALL_IF2   = 1;
    localparam int unsigned STALL_ID    = 2;

    // addi x0,x0,0
    localparam logic [INST_W-1:0] DEF_NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0]   DEF_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic              valid;
        logic              excp_misalign;
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } if22id_t;

    typedef struct packed {
        logic            br_e;
        logic [XLEN-1:0] br_addr;
    } br_bus_t;

endpackage

// File: rtl/if2_inst_buf.sv
// One-entry instruction hold buffer. Captures data while the consumer is
// stalled so a changing SRAM output cannot corrupt it; clear wins over capture.
// Ports: clk, rst_n (sync, active-low), clr (drop entry), cap (load din when
//        not cleared), din, buf_v / buf_data (registered entry).
module if2_inst_buf
    import if2_stage_pkg::*;
#(
    parameter logic [INST_W-1:0] RESET_DATA = DEF_NOP_INST
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              cap,
    input  logic [INST_W-1:0] din,
    output logic              buf_v,
    output logic [INST_W-1:0] buf_data
);

    // Buffer state: reset > clear > capture > hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_v    <= 1'b0;
            buf_data <= RESET_DATA;
        end else if (clr) begin
            buf_v    <= 1'b0;
        end else if (cap) begin
            buf_v    <= 1'b1;
            buf_data <= din;
        end
    end

endmodule

// File: rtl/if2_stage.sv
// Second instruction-fetch stage. Registers the IF1 fetch PC, pairs it with
// the 1-cycle-latency inst SRAM data, holds the instruction across stalls and
// kills wrong-path fetches on branch redirect.
// Ports: clk, rst_n (sync, active-low), stall (pipeline stall vector),
//        if12if2_bus (fetch PC), if1_valid (IF1 issued a fetch),
//        br_bus ({br_e, br_addr}), inst_sram_rdata,
//        if22id_bus ({valid, excp_misalign, pc, inst}, combinational).
module if2_stage
    import if2_stage_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST,
    parameter logic [XLEN-1:0]   RESET_PC = DEF_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [STALL_W-1:0]    stall,
    input  logic [IF12IF2_WD-1:0] if12if2_bus,
    input  logic                  if1_valid,
    input  logic [BR_BUS_WD-1:0]  br_bus,
    input  logic [INST_W-1:0]     inst_sram_rdata,
    output logic [IF22ID_WD-1:0]  if22id_bus
);

    br_bus_t           br_s;
    logic              br_e;
    logic              hold_if2;
    logic              hold_id;
    logic [XLEN-1:0]   pc_in;

    logic              v_r;
    logic [XLEN-1:0]   pc_r;
    logic              buf_v;
    logic [INST_W-1:0] buf_inst;
    logic              buf_clr;
    logic              buf_cap;

    logic [INST_W-1:0] inst_sel;
    logic              valid_o;
    if22id_t           bus_s;

    assign br_s     = br_bus;
    assign br_e     = br_s.br_e;
    assign hold_if2 = stall[STALL_IF2];
    assign hold_id  = stall[STALL_ID];
    assign pc_in    = if12if2_bus;

    // Redirect target and other stages' stall bits are consumed elsewhere.
    logic unused_ok;
    assign unused_ok = ^{br_s.br_addr, stall[STALL_IF1], stall[STALL_W-1:STALL_ID+1]};

    // Valid/PC register: reset > flush > hold > advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_r  <= 1'b0;
            pc_r <= RESET_PC;
        end else if (br_e) begin
            v_r  <= 1'b0;
            pc_r <= pc_in;
        end else if (hold_if2) begin
            // ID drains while IF2 holds: leave a bubble behind.
            if (!hold_id) begin
                v_r <= 1'b0;
            end
        end else begin
            v_r  <= if1_valid;
            pc_r <= pc_in;
        end
    end

    // Buffer only survives a full IF2+ID hold; everything else releases it.
    assign buf_clr = br_e | ~hold_if2 | ~hold_id;
    assign buf_cap = v_r & ~buf_v;

    if2_inst_buf #(
        .RESET_DATA (NOP_INST)
    ) u_inst_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (buf_clr),
        .cap      (buf_cap),
        .din      (inst_sram_rdata),
        .buf_v    (buf_v),
        .buf_data (buf_inst)
    );

    // Output bus; br_e kills the same cycle so wrong-path code never reaches ID.
    always_comb begin
        inst_sel            = buf_v ? buf_inst : inst_sram_rdata;
        valid_o             = v_r & ~br_e;
        bus_s.valid         = valid_o;
        bus_s.excp_misalign = valid_o & (pc_r[1:0] != 2'b00);
        bus_s.pc            = pc_r;
        bus_s.inst          = valid_o ? inst_sel : NOP_INST;
    end

    assign if22id_bus = bus_s;

endmodule
